// File: rtl/ll_fifo_drain_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ll_fifo_drain_arbiter_if
// Brief    : Pop-side bus toward the shared linked-list FIFO plus the tagged
//            valid/ready output stream of the drain arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface ll_fifo_drain_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0] empty;
    logic [WIDTH-1:0]     ll_data;
    logic                 pop;
    logic [SEL_WIDTH-1:0] pop_sel;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_WIDTH-1:0] out_qid;

    // master: the arbiter; slave: the shared FIFO plus downstream consumer
    modport master (
        input  empty, ll_data, out_ready,
        output pop, pop_sel, out_valid, out_data, out_qid
    );

    modport slave (
        output empty, ll_data, out_ready,
        input  pop, pop_sel, out_valid, out_data, out_qid
    );
endinterface
`default_nettype wire

// File: rtl/ll_fifo_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ll_fifo_drain_arbiter
// Brief    : Round-robin read engine for linked_list_fifo; pops non-empty
//            queues under a 2-slot credit and streams {qid,data} out.
// Revision : 1.0  initial release
// ============================================================================
module ll_fifo_drain_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int RD_LAT    = 1,
    parameter int CNT_WIDTH = 16,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en,
    ll_fifo_drain_arbiter_if.master    bus,
    output logic                       busy,
    output logic [CNT_WIDTH-1:0]       pop_cnt
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam int         c_IDX_W    = SEL_WIDTH + 1;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [SEL_WIDTH-1:0] r_rr_ptr;
    logic [SEL_WIDTH-1:0] w_rr_nxt;
    logic [CNT_WIDTH-1:0] r_pop_cnt;

    logic [WIDTH-1:0]     r_buf_data [2];
    logic [SEL_WIDTH-1:0] r_buf_qid  [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_deq;
    logic                 w_enq;
    logic [SEL_WIDTH-1:0] w_enq_qid;
    logic                 w_inflight;
    logic [1:0]           w_occ;
    logic                 w_credit;
    logic [SEL_WIDTH-1:0] w_sel;
    logic                 w_found;
    logic                 w_pop;

    assign w_deq = (r_count != 2'd0) && bus.out_ready;

    // A word leaving this cycle frees its slot; an outstanding read still holds one.
    assign w_occ    = r_count - {1'b0, w_deq} + {1'b0, w_inflight};
    assign w_credit = (w_occ < 2'd2);

    always_comb begin : p_arb
        logic [c_IDX_W-1:0] idx;
        idx     = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            idx = {1'b0, r_rr_ptr} + c_IDX_W'(i);
            if (idx >= c_IDX_W'(NUM_FIFOS)) begin
                idx = idx - c_IDX_W'(NUM_FIFOS);
            end
            if (!w_found && !bus.empty[idx[SEL_WIDTH-1:0]]) begin
                w_sel   = idx[SEL_WIDTH-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_rr_nxt = (w_sel == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : (w_sel + SEL_WIDTH'(1));

    assign w_pop       = (r_state == c_ST_RUN) && w_found && w_credit;
    assign bus.pop     = w_pop;
    assign bus.pop_sel = w_pop ? w_sel : '0;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_inflight = 1'b0;
            assign w_enq      = w_pop;
            assign w_enq_qid  = w_sel;
        end else begin : g_lat1
            logic                 r_infl_vld;
            logic [SEL_WIDTH-1:0] r_infl_qid;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_infl_vld <= 1'b0;
                    r_infl_qid <= '0;
                end else begin
                    r_infl_vld <= w_pop;
                    if (w_pop) begin
                        r_infl_qid <= w_sel;
                    end
                end
            end

            assign w_inflight = r_infl_vld;
            assign w_enq      = r_infl_vld;
            assign w_enq_qid  = r_infl_qid;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                r_buf_data[k] <= '0;
                r_buf_qid[k]  <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_buf_data[r_wr_ptr] <= bus.ll_data;
                r_buf_qid[r_wr_ptr]  <= w_enq_qid;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = r_buf_data[r_rd_ptr];
    assign bus.out_qid   = r_buf_qid[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (en) w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (!en) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: begin
                if (en) begin
                    w_state_nxt = c_ST_RUN;
                end else if (!w_inflight && (r_count == 2'd0)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_rr_ptr  <= '0;
            r_pop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_rr_ptr  <= w_rr_nxt;
                r_pop_cnt <= r_pop_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign pop_cnt = r_pop_cnt;
    assign busy    = (r_state != c_ST_IDLE) || w_inflight || (r_count != 2'd0);

endmodule
`default_nettype wire
